// File: rtl/btn_debouncer_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module : btn_debouncer_bank_pkg
// Brief  : Shared defaults, per-channel status type and counter-width helper.
// Rev    : 1.0 - initial release
// ============================================================================
package btn_debouncer_bank_pkg;

  localparam int unsigned C_DEF_CHANNELS         = 4;
  localparam int unsigned C_DEF_TICK_DIV         = 100000;
  localparam int unsigned C_DEF_STABLE_COUNT     = 8;
  localparam int unsigned C_DEF_LONG_PRESS_TICKS = 1000;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic long_press;
  } ch_out_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debouncer_bank_if.sv
`default_nettype none
// ============================================================================
// Module : btn_debouncer_bank_if
// Brief  : Raw pin inputs and conditioned per-channel outputs of the bank.
// Rev    : 1.0 - initial release
// ============================================================================
interface btn_debouncer_bank_if #(
  parameter int unsigned CHANNELS = 4
);

  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] long_press;

  modport master (
    output btn_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  long_press
  );

  modport slave (
    input  btn_in,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output long_press
  );

endinterface
`default_nettype wire

// File: rtl/btn_debouncer_bank_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module : debounce_channel
// Brief  : One channel: synchroniser, tick-based stability filter, edge pulses
//          and optional long-press detector.
// Rev    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import btn_debouncer_bank_pkg::*;
#(
  parameter int unsigned STABLE_COUNT     = C_DEF_STABLE_COUNT,
  parameter int unsigned LONG_PRESS_TICKS = C_DEF_LONG_PRESS_TICKS,
  parameter logic        INVERT           = 1'b0
) (
  input  wire logic    clk,
  input  wire logic    rst,
  input  wire logic    i_tick,
  input  wire logic    i_pin,
  output ch_out_t      o_status
);

  localparam int unsigned      C_SW   = cnt_width(STABLE_COUNT + 1);
  localparam logic [C_SW-1:0]  C_LAST = C_SW'(STABLE_COUNT - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic [C_SW-1:0] r_cnt;
  logic            r_level;
  logic            r_rise;
  logic            r_fall;
  logic            w_sample;
  logic            w_long;

  // Flops reset to INVERT so the corrected sample starts at 0.
  assign w_sample = r_sync2 ^ INVERT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= INVERT;
      r_sync2 <= INVERT;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (i_tick) begin
        if (w_sample == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
          r_rise  <= ~r_level;
          r_fall  <= r_level;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  generate
    if (LONG_PRESS_TICKS > 0) begin : g_long
      localparam int unsigned     C_HW   = cnt_width(LONG_PRESS_TICKS + 1);
      localparam logic [C_HW-1:0] C_HMAX = C_HW'(LONG_PRESS_TICKS);

      logic [C_HW-1:0] r_hold;
      logic            r_long;

      // Saturation at C_HMAX is what suppresses repeats while held.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_hold <= '0;
          r_long <= 1'b0;
        end else begin
          r_long <= 1'b0;
          if (!r_level) begin
            r_hold <= '0;
          end else if (i_tick && (r_hold != C_HMAX)) begin
            r_hold <= r_hold + 1'b1;
            r_long <= (r_hold == (C_HMAX - 1'b1));
          end
        end
      end

      assign w_long = r_long;
    end else begin : g_no_long
      assign w_long = 1'b0;
    end
  endgenerate

  assign o_status.level      = r_level;
  assign o_status.rise       = r_rise;
  assign o_status.fall       = r_fall;
  assign o_status.long_press = w_long;

endmodule
`default_nettype wire

// File: rtl/btn_debouncer_bank.sv
`default_nettype none
// ============================================================================
// Module : btn_debouncer_bank
// Brief  : Bank of independent debounce channels sharing one sample prescaler.
// Rev    : 1.0 - initial release
// ============================================================================
module btn_debouncer_bank
  import btn_debouncer_bank_pkg::*;
#(
  parameter int unsigned         CHANNELS         = C_DEF_CHANNELS,
  parameter int unsigned         TICK_DIV         = C_DEF_TICK_DIV,
  parameter int unsigned         STABLE_COUNT     = C_DEF_STABLE_COUNT,
  parameter int unsigned         LONG_PRESS_TICKS = C_DEF_LONG_PRESS_TICKS,
  parameter logic [CHANNELS-1:0] INVERT           = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  btn_debouncer_bank_if.slave   bus
);

  localparam int unsigned     C_PW    = cnt_width(TICK_DIV);
  localparam logic [C_PW-1:0] C_PLAST = C_PW'(TICK_DIV - 1);

  logic [C_PW-1:0] r_presc;
  logic            w_tick;
  ch_out_t         w_status [CHANNELS];

  assign w_tick = (r_presc == C_PLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_ch
      debounce_channel #(
        .STABLE_COUNT     (STABLE_COUNT),
        .LONG_PRESS_TICKS (LONG_PRESS_TICKS),
        .INVERT           (INVERT[gi])
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (w_tick),
        .i_pin    (bus.btn_in[gi]),
        .o_status (w_status[gi])
      );
    end
  endgenerate

  always_comb begin
    bus.level_out  = '0;
    bus.rise_pulse = '0;
    bus.fall_pulse = '0;
    bus.long_press = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      bus.level_out[i]  = w_status[i].level;
      bus.rise_pulse[i] = w_status[i].rise;
      bus.fall_pulse[i] = w_status[i].fall;
      bus.long_press[i] = w_status[i].long_press;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_debouncer_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_btn_debouncer_bank
// Brief  : Directed and random stimulus against a tick-counting reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_btn_debouncer_bank;

  localparam int          CH  = 2;
  localparam int          TD  = 4;
  localparam int          SC  = 3;
  localparam int          LPT = 5;
  localparam logic [1:0]  INV = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_debouncer_bank_if #(.CHANNELS(CH)) bus ();

  btn_debouncer_bank #(
    .CHANNELS         (CH),
    .TICK_DIV         (TD),
    .STABLE_COUNT     (SC),
    .LONG_PRESS_TICKS (LPT),
    .INVERT           (INV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pin history, tick phase, run of disagreeing ticks, ticks held high.
  int            m_phase;
  int            m_run  [CH];
  int            m_held [CH];
  bit            m_lvl  [CH];
  bit            m_h1   [CH];
  bit            m_h2   [CH];
  bit [CH-1:0]   m_rise, m_fall, m_long;

  always @(posedge clk or posedge rst) begin
    bit tick;
    bit s;
    bit old;
    if (rst) begin
      m_phase = 0;
      m_rise = '0; m_fall = '0; m_long = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c] = 0; m_held[c] = 0; m_lvl[c] = 1'b0;
        m_h1[c] = INV[c]; m_h2[c] = INV[c];
      end
    end else begin
      tick    = (m_phase == TD - 1);
      m_phase = (m_phase + 1) % TD;
      m_rise = '0; m_fall = '0; m_long = '0;
      for (int c = 0; c < CH; c++) begin
        s       = m_h2[c] ^ INV[c];
        m_h2[c] = m_h1[c];
        m_h1[c] = bus.btn_in[c];
        old     = m_lvl[c];
        if (!old) m_held[c] = 0;
        else if (tick && m_held[c] < LPT) begin
          m_held[c]++;
          if (m_held[c] == LPT) m_long[c] = 1'b1;
        end
        if (tick) begin
          if (s == old) m_run[c] = 0;
          else begin
            m_run[c]++;
            if (m_run[c] == SC) begin
              m_lvl[c] = ~old;
              m_run[c] = 0;
              if (old) m_fall[c] = 1'b1; else m_rise[c] = 1'b1;
            end
          end
        end
      end
    end
  end

  int cyc = 0;
  int n_rise0 = 0, n_fall0 = 0, n_long0 = 0;
  int last_rise_cyc = 0, last_long_cyc = 0;
  bit any_act = 1'b0;
  bit seen_rise11 = 1'b0;

  always @(posedge clk) begin
    logic [CH-1:0] exp_lvl;
    #1;
    cyc++;
    for (int c = 0; c < CH; c++) exp_lvl[c] = m_lvl[c];
    check("outputs{lvl,rise,fall,long}",
          {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_press},
          {exp_lvl, m_rise, m_fall, m_long});
    check("rise_fall_exclusive", bus.rise_pulse & bus.fall_pulse, '0);
    if (bus.rise_pulse[0]) begin n_rise0++; last_rise_cyc = cyc; end
    if (bus.fall_pulse[0]) n_fall0++;
    if (bus.long_press[0]) begin n_long0++; last_long_cyc = cyc; end
    if (|{bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.long_press}) any_act = 1'b1;
    if (bus.rise_pulse == 2'b11) seen_rise11 = 1'b1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count clock edges until level_out[0] reaches the wanted value (bounded).
  task automatic wait_level0(input bit want, output int lat);
    lat = 0;
    while (bus.level_out[0] !== want && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int k;
    bus.btn_in = 2'b10;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;

    // Idle after reset, ch1 pin high but active-low.
    any_act = 1'b0;
    cycles(100);
    check("reset_idle_activity", any_act, 1'b0);

    // Bounce every 5 cycles: never three agreeing ticks in a row.
    n_rise0 = 0;
    for (int i = 0; i < 12; i++) begin
      bus.btn_in[0] = (i % 2 == 0);
      cycles(5);
    end
    check("bounce_quiet", any_act, 1'b0);
    bus.btn_in[0] = 1'b1;
    wait_level0(1'b1, lat);
    check("step_latency_11_to_14", (lat >= 11 && lat <= 14), 1'b1);
    cycles(2);
    check("bounce_single_rise", n_rise0, 1);

    // Long press: five ticks after the rise, once only.
    n_long0 = 0; n_fall0 = 0;
    cycles(22);
    check("long_press_count", n_long0, 1);
    check("long_press_delay", last_long_cyc - last_rise_cyc, 20);
    cycles(80);
    check("long_press_no_repeat", n_long0, 1);
    bus.btn_in[0] = 1'b0;
    cycles(20);
    check("release_fall_count", n_fall0, 1);
    check("release_level", bus.level_out[0], 1'b0);
    bus.btn_in[0] = 1'b1;
    cycles(20);
    cycles(22);
    check("repress_long_count", n_long0, 2);
    check("repress_long_delay", last_long_cyc - last_rise_cyc, 20);

    // Async reset mid-cycle while a falling run is at 2 ticks.
    bus.btn_in[0] = 1'b0;
    k = 0;
    while (m_run[0] != 2 && k < 40) begin @(negedge clk); k++; end
    #2 rst = 1'b1;
    #1;
    check("async_rst_level", bus.level_out, 2'b00);
    check("async_rst_pulses", {bus.rise_pulse, bus.fall_pulse, bus.long_press}, 6'b0);
    @(negedge clk);
    bus.btn_in[0] = 1'b1;
    rst = 1'b0;
    wait_level0(1'b1, lat);
    check("post_rst_latency", lat, 12);

    // Both channels go active on the same cycle.
    bus.btn_in[0] = 1'b0;
    cycles(30);
    seen_rise11 = 1'b0;
    bus.btn_in = 2'b01;
    cycles(20);
    check("simultaneous_rise", seen_rise11, 1'b1);
    check("simultaneous_level", bus.level_out, 2'b11);

    // Random pin activity, model checks every cycle.
    for (int i = 0; i < 200; i++) begin
      bus.btn_in = 2'($urandom_range(0, 3));
      cycles($urandom_range(1, 20));
    end
    cycles(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_debouncer_bank.md
# btn_debouncer_bank

Parametrised multi-channel push-button conditioner: a bank of CHANNELS independent debounce channels behind a shared sample-tick prescaler. It sits between the raw board button/switch pins and the control FSMs. Per channel it provides a stable level, single-cycle rise/fall pulses and an optional long-press pulse, replacing ad-hoc single-button debouncing plus downstream edge detectors.

## Interface
- CHANNELS, 4, number of independent inputs (≥1)
- TICK_DIV, 100000, clk cycles per sample tick (≥2; 1 ms at 100 MHz)
- STABLE_COUNT, 8, consecutive ticks a new value must persist before level changes (≥1)
- LONG_PRESS_TICKS, 1000, ticks of continuous high level before long_press fires; 0 disables
- INVERT, {CHANNELS{1'b0}}, per-channel mask; 1 = active-low pin, inverted after synchronisation

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_in  in  CHANNELS  raw asynchronous button pins
- level_out  out  CHANNELS  debounced, polarity-corrected level
- rise_pulse  out  CHANNELS  one-cycle pulse on level 0→1
- fall_pulse  out  CHANNELS  one-cycle pulse on level 1→0
- long_press  out  CHANNELS  one-cycle pulse when held LONG_PRESS_TICKS

## Operation
- Reset (async, rst=1): all outputs 0; prescaler 0; stability and hold counters 0; synchroniser flops load INVERT so post-inversion sample is 0.
- Synchroniser: 2 flops per channel, then XOR with INVERT → sample.
- Prescaler: counts 0..TICK_DIV-1, wraps; tick=1 for exactly one cycle when count==TICK_DIV-1. One prescaler shared by all channels.
- Stability counter per channel, width $clog2(STABLE_COUNT+1), updated only on tick:
  - sample==level: clear to 0.
  - sample!=level and cnt==STABLE_COUNT-1: toggle level, clear cnt.
  - otherwise cnt+1. Never exceeds STABLE_COUNT-1.
- Edge pulses: registered, asserted in the first cycle level_out shows the new value, deasserted next cycle. rise and fall never both high in one channel.
- Long press: hold counter (width $clog2(LONG_PRESS_TICKS+1)) increments on tick while level=1, saturating at LONG_PRESS_TICKS; long_press pulses one cycle on the tick where it reaches LONG_PRESS_TICKS; no repeat until level returns to 0, which clears the counter. LONG_PRESS_TICKS=0: long_press tied 0, counter removed.
- Channels fully independent; simultaneous events across channels produce simultaneous outputs.

## Timing
- Pin to sample: 2 clk cycles.
- Clean step: level_out changes on the clock edge of the STABLE_COUNT-th tick at which the changed sample is observed; worst case 2 + STABLE_COUNT·TICK_DIV cycles, best 2 + (STABLE_COUNT-1)·TICK_DIV + 1.
- Any reversion sampled on a tick before STABLE_COUNT restarts the count; glitches entirely between ticks are invisible.
- rst deasserted mid-operation: first tick TICK_DIV cycles after deassertion.

## Structure
- Shared include header: default parameter values, prescaler counter width function.
- Sub-module debounce_channel (synchroniser, stability counter, level, edge and long-press logic), instantiated CHANNELS times by a generate loop; prescaler lives in the top.

## Test plan
Bench parameters: CHANNELS=2, TICK_DIV=4, STABLE_COUNT=3, LONG_PRESS_TICKS=5, INVERT=2'b10.
- Reset with btn_in=2'b10 (ch1 idle-high) → all outputs 0, stay 0 for 100 cycles.
- ch0 clean 0→1 step → level_out[0] rises on 3rd tick after sync; rise_pulse[0] high exactly 1 cycle, same cycle; fall_pulse 0.
- ch0 toggling every 5 cycles for 60 cycles, then steady 1 → no output activity during bouncing; exactly one rise_pulse afterwards.
- ch0 held high 5 ticks past level rise → one long_press[0] pulse; held 20 more ticks → no more; release → one fall_pulse[0], re-press repeats long_press after 5 ticks.
- rst asserted asynchronously (mid-clock) with ch0 cnt=2 → outputs 0 immediately; after release ch0 needs full 3 ticks again.
- ch0 rises and ch1 pin goes 1→0 same cycle → rise_pulse=2'b11 in one cycle, level_out=2'b11.
